udt_tx_arbiter: RTL

//  Shares the single 64-bit UDP TX stream between two UDT packet sources: the control-packet

---
 rtl/udt_pkg.sv | 20 ++
 rtl/udt_axis_mux2.sv | 48 ++++
 rtl/udt_tx_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/udt_pkg.sv
// Shared definitions for the UDT transmit path.
//   - AXIS stream widths used by every UDT TX block
//   - arbiter state encoding
//   - source identifiers used as the mux select
package udt_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;

    // IDLE decides the next grant; CTRL/DATA own the stream until a tlast beat
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic SRC_CTRL = 1'b0;
    localparam logic SRC_DATA = 1'b1;

endpackage

// File: rtl/udt_axis_mux2.sv
// Combinational 2:1 AXIS multiplexer.
// Ports:
//   en            1 = a source is granted; 0 = output idle, both sources stalled
//   sel           granted source (SRC_CTRL / SRC_DATA)
//   ctrl_*        control-packet source stream (tready is an output)
//   data_*        data-packet source stream (tready is an output)
//   out_*         merged stream towards the UDP stack (tready is an input)
module udt_axis_mux2
    import udt_pkg::*;
(
    input  logic                   en,
    input  logic                   sel,
    input  logic                   ctrl_tvalid,
    output logic                   ctrl_tready,
    input  logic [AXIS_DATA_W-1:0] ctrl_tdata,
    input  logic [AXIS_KEEP_W-1:0] ctrl_tkeep,
    input  logic                   ctrl_tlast,
    input  logic                   data_tvalid,
    output logic                   data_tready,
    input  logic [AXIS_DATA_W-1:0] data_tdata,
    input  logic [AXIS_KEEP_W-1:0] data_tkeep,
    input  logic                   data_tlast,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic [AXIS_DATA_W-1:0] out_tdata,
    output logic [AXIS_KEEP_W-1:0] out_tkeep,
    output logic                   out_tlast
);

    // Payload follows the selected source; valid and ready are gated so that
    // nothing moves while no grant is held and the losing source always stalls.
    always_comb begin
        if (sel == SRC_DATA) begin
            out_tdata  = data_tdata;
            out_tkeep  = data_tkeep;
            out_tlast  = data_tlast;
            out_tvalid = en & data_tvalid;
        end else begin
            out_tdata  = ctrl_tdata;
            out_tkeep  = ctrl_tkeep;
            out_tlast  = ctrl_tlast;
            out_tvalid = en & ctrl_tvalid;
        end
        ctrl_tready = en & (sel == SRC_CTRL) & out_tready;
        data_tready = en & (sel == SRC_DATA) & out_tready;
    end

endmodule

// File: rtl/udt_tx_arbiter.sv
// Packet-boundary arbiter sharing the UDP TX stream between the UDT control
// packet generator and the data packet sender. Control wins ties, but after
// MAX_CTRL_BURST back-to-back control grants with data waiting, data is served.
// Ports:
//   core_clk, core_rst        clock, asynchronous active-high reset
//   arb_en                    allow new grants (a packet in flight always completes)
//   ctrl_* / data_*           source AXIS streams plus per-packet destination ip/port
//   udp_tx_t*                 merged AXIS stream to the UDP/IP stack
//   udp_tx_mac_*/ip_*/port_*  header fields; destinations latched at grant
//   ctrl_pkt_cnt, data_pkt_cnt  completed packets per source (wrapping)
//   busy                      a grant is currently held
module udt_tx_arbiter
    import udt_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC_SRC   = 48'hba0203040506,
    parameter logic [47:0] FPGA_MAC_DES   = 48'hffffffffffff,
    parameter logic [31:0] FPGA_IP_SRC    = 32'hc0a8006f,
    parameter int          PORT           = 10086,
    parameter int          MAX_CTRL_BURST = 4
) (
    input  logic                   core_clk,
    input  logic                   core_rst,
    input  logic                   arb_en,
    input  logic                   ctrl_tvalid,
    output logic                   ctrl_tready,
    input  logic [AXIS_DATA_W-1:0] ctrl_tdata,
    input  logic [AXIS_KEEP_W-1:0] ctrl_tkeep,
    input  logic                   ctrl_tlast,
    input  logic [31:0]            ctrl_ip_dest,
    input  logic [15:0]            ctrl_port_dest,
    input  logic                   data_tvalid,
    output logic                   data_tready,
    input  logic [AXIS_DATA_W-1:0] data_tdata,
    input  logic [AXIS_KEEP_W-1:0] data_tkeep,
    input  logic                   data_tlast,
    input  logic [31:0]            data_ip_dest,
    input  logic [15:0]            data_port_dest,
    input  logic                   udp_tx_tready,
    output logic                   udp_tx_tvalid,
    output logic [AXIS_DATA_W-1:0] udp_tx_tdata,
    output logic [AXIS_KEEP_W-1:0] udp_tx_tkeep,
    output logic                   udp_tx_tlast,
    output logic [47:0]            udp_tx_mac_src,
    output logic [47:0]            udp_tx_mac_dest,
    output logic [31:0]            udp_tx_ip_src,
    output logic [31:0]            udp_tx_ip_dest,
    output logic [15:0]            udp_tx_port_src,
    output logic [15:0]            udp_tx_port_dest,
    output logic [31:0]            ctrl_pkt_cnt,
    output logic [31:0]            data_pkt_cnt,
    output logic                   busy
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_CTRL_BURST);

    arb_state_t state;
    arb_state_t state_next;
    logic [3:0] streak;
    logic       grant_ctrl;
    logic       grant_data;
    logic       beat_fire;
    logic       pkt_done;

    assign udp_tx_mac_src  = FPGA_MAC_SRC;
    assign udp_tx_mac_dest = FPGA_MAC_DES;
    assign udp_tx_ip_src   = FPGA_IP_SRC;
    assign udp_tx_port_src = PORT[15:0];
    assign busy            = (state != IDLE);
    assign beat_fire       = udp_tx_tvalid & udp_tx_tready;
    assign pkt_done        = beat_fire & udp_tx_tlast;

    udt_axis_mux2 u_mux (
        .en          (state != IDLE),
        .sel         ((state == DATA) ? SRC_DATA : SRC_CTRL),
        .ctrl_tvalid (ctrl_tvalid),
        .ctrl_tready (ctrl_tready),
        .ctrl_tdata  (ctrl_tdata),
        .ctrl_tkeep  (ctrl_tkeep),
        .ctrl_tlast  (ctrl_tlast),
        .data_tvalid (data_tvalid),
        .data_tready (data_tready),
        .data_tdata  (data_tdata),
        .data_tkeep  (data_tkeep),
        .data_tlast  (data_tlast),
        .out_tvalid  (udp_tx_tvalid),
        .out_tready  (udp_tx_tready),
        .out_tdata   (udp_tx_tdata),
        .out_tkeep   (udp_tx_tkeep),
        .out_tlast   (udp_tx_tlast)
    );

    // Grant decision happens only in IDLE, so every packet is followed by at
    // least one idle cycle. Control is refused only when data is waiting and
    // the control streak has already reached its limit.
    always_comb begin
        state_next = state;
        grant_ctrl = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (arb_en) begin
                    if (ctrl_tvalid && !(data_tvalid && streak == BURST_LIMIT)) begin
                        state_next = CTRL;
                        grant_ctrl = 1'b1;
                    end else if (data_tvalid) begin
                        state_next = DATA;
                        grant_data = 1'b1;
                    end
                end
            end
            CTRL, DATA: begin
                if (pkt_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control streak only grows while data is actually waiting; a control
    // grant with no data pending means there is nobody to starve.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            streak <= '0;
        end else if (grant_ctrl) begin
            if (!data_tvalid) begin
                streak <= '0;
            end else if (streak != BURST_LIMIT) begin
                streak <= streak + 4'd1;
            end
        end else if (grant_data) begin
            streak <= '0;
        end
    end

    // Destination header is captured once per packet so it stays stable even
    // if the source changes its ip/port inputs mid-packet.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            udp_tx_ip_dest   <= '0;
            udp_tx_port_dest <= '0;
        end else if (grant_ctrl) begin
            udp_tx_ip_dest   <= ctrl_ip_dest;
            udp_tx_port_dest <= ctrl_port_dest;
        end else if (grant_data) begin
            udp_tx_ip_dest   <= data_ip_dest;
            udp_tx_port_dest <= data_port_dest;
        end
    end

    // Completed-packet statistics, counted on the tlast beat of each source.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            ctrl_pkt_cnt <= '0;
            data_pkt_cnt <= '0;
        end else if (pkt_done) begin
            if (state == CTRL) begin
                ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
            end else if (state == DATA) begin
                data_pkt_cnt <= data_pkt_cnt + 32'd1;
            end
        end
    end

endmodule
